// File: rtl/redun_mont_seq.sv
// Sequencer for a chain of T repeated squarings through an external squarer.
// Operands are opaque packed words; this block only issues, counts and collects them.
module redun_mont_seq #(
  parameter int DAT_BITS = 2048,
  parameter int CNT_BITS = 40,
  parameter int TIMEOUT  = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [DAT_BITS-1:0] i_sq,
  input  logic [CNT_BITS-1:0] i_iter,
  input  logic                i_abort,
  output logic [DAT_BITS-1:0] o_mul_sq,
  output logic                o_mul_val,
  input  logic [DAT_BITS-1:0] i_mul,
  input  logic                i_mul_val,
  input  logic                i_overflow,
  output logic                o_busy,
  output logic                o_done,
  output logic [DAT_BITS-1:0] o_result,
  output logic [CNT_BITS-1:0] o_iter_cnt,
  output logic                o_err
);

  localparam int TMR_BITS = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_BITS-1:0] TMR_LAST = TMR_BITS'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  logic [DAT_BITS-1:0] cur;
  logic [CNT_BITS-1:0] tgt;
  logic [TMR_BITS-1:0] timer;
  logic [CNT_BITS-1:0] next_cnt;

  // The running value doubles as the squarer operand, so the operand bus is a register.
  assign o_mul_sq = cur;
  assign next_cnt = o_iter_cnt + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      cur        <= '0;
      tgt        <= '0;
      timer      <= '0;
      o_mul_val  <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_result   <= '0;
      o_iter_cnt <= '0;
      o_err      <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so any branch that raises them yields exactly one cycle.
      o_mul_val <= 1'b0;
      o_done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            o_iter_cnt <= '0;
            if (i_iter != '0) begin
              cur       <= i_sq;
              tgt       <= i_iter;
              o_mul_val <= 1'b1;
              o_busy    <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              o_result <= i_sq;
              o_done   <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (i_abort) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end else begin
            timer <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_abort) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end else if (i_mul_val) begin
            if (i_overflow) begin
              o_err  <= 1'b1;
              o_busy <= 1'b0;
              state  <= S_ERR;
            end else begin
              cur        <= i_mul;
              o_iter_cnt <= next_cnt;
              if (next_cnt == tgt) begin
                o_result <= i_mul;
                o_done   <= 1'b1;
                o_busy   <= 1'b0;
                state    <= S_DONE;
              end else begin
                // Re-issue on the very next cycle to keep turnaround at one clock.
                o_mul_val <= 1'b1;
                state     <= S_ISSUE;
              end
            end
          end else if (timer == TMR_LAST) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= S_ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_ERR: begin
          if (i_abort) begin
            o_err <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_redun_mont_seq.sv
// Directed bench for redun_mont_seq with a latency-4 stub squarer (x^2 mod 1000003).
module tb_redun_mont_seq;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          i_clk, i_rst, i_start, i_abort;
  logic [DW-1:0] i_sq, i_mul, o_mul_sq, o_result;
  logic [CW-1:0] i_iter, o_iter_cnt;
  logic          o_mul_val, i_mul_val, i_overflow, o_busy, o_done, o_err;

  int tests  = 0;
  int failed = 0;
  int edge_cnt = 0;
  int mv_q[$];
  int done_q[$];

  redun_mont_seq #(.DAT_BITS(DW), .CNT_BITS(CW), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_sq(i_sq), .i_iter(i_iter),
    .i_abort(i_abort), .o_mul_sq(o_mul_sq), .o_mul_val(o_mul_val), .i_mul(i_mul),
    .i_mul_val(i_mul_val), .i_overflow(i_overflow), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_iter_cnt(o_iter_cnt), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  // Event log: an entry n means the signal is sampled high at rising edge n.
  always @(negedge i_clk) begin
    if (o_mul_val) mv_q.push_back(edge_cnt + 1);
    if (o_done)    done_q.push_back(edge_cnt + 1);
  end

  // Stub squarer: operand sampled at edge e returns a result sampled at edge e+4.
  logic [3:0]    v;
  logic [DW-1:0] d [4];
  int            res_num = 0;
  int            ovf_at  = 0;
  logic          mute    = 1'b0;

  function automatic logic [DW-1:0] sq_mod(input logic [DW-1:0] x);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, x};
    return DW'(p % 64'd1000003);
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v <= '0;
      for (int i = 0; i < 4; i++) d[i] <= '0;
    end else begin
      v    <= {v[2:0], o_mul_val & ~mute};
      d[0] <= sq_mod(o_mul_sq);
      d[1] <= d[0];
      d[2] <= d[1];
      d[3] <= d[2];
      if (v[3]) res_num <= res_num + 1;
    end
  end

  assign i_mul_val  = v[3];
  assign i_mul      = d[3];
  assign i_overflow = v[3] && (res_num + 1 == ovf_at);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic start_chain(input logic [DW-1:0] sq, input logic [CW-1:0] it, output int k);
    i_sq    = sq;
    i_iter  = it;
    i_start = 1'b1;
    k       = edge_cnt + 1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_q.size() != 0 || o_err) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  task automatic clear_log();
    mv_q.delete();
    done_q.delete();
  endtask

  initial begin
    int k, k2, ok, err_edge;
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_sq = '0; i_iter = '0;
    step(); step();
    check("rst mul_val", o_mul_val, 0);
    check("rst done", o_done, 0);
    check("rst busy", o_busy, 0);
    check("rst err", o_err, 0);
    check("rst mul_sq", o_mul_sq, 0);
    check("rst result", o_result, 0);
    check("rst iter_cnt", o_iter_cnt, 0);
    i_rst = 1'b0;
    step();

    // Three squarings of 3: 9, 81, 6561.
    clear_log();
    start_chain(3, 3, k);
    check("a busy", o_busy, 1);
    wait_end(100, ok);
    check("a finished", ok, 1);
    step(); step();
    check("a mv count", mv_q.size(), 3);
    if (mv_q.size() == 3) begin
      check("a mv0", mv_q[0], k + 1);
      check("a mv1", mv_q[1], k + 6);
      check("a mv2", mv_q[2], k + 11);
    end
    check("a done count", done_q.size(), 1);
    if (done_q.size() == 1) check("a done edge", done_q[0], k + 16);
    check("a result", o_result, 6561);
    check("a iter_cnt", o_iter_cnt, 3);
    check("a busy idle", o_busy, 0);

    // Zero iterations: immediate completion, no squarer traffic.
    clear_log();
    start_chain(7, 0, k);
    wait_end(20, ok);
    check("b finished", ok, 1);
    step(); step();
    check("b mv count", mv_q.size(), 0);
    check("b done count", done_q.size(), 1);
    if (done_q.size() == 1) check("b done edge", done_q[0], k + 1);
    check("b result", o_result, 7);
    check("b iter_cnt", o_iter_cnt, 0);

    // Muted squarer: timeout to ERR, start ignored, abort clears.
    clear_log();
    mute = 1'b1;
    start_chain(3, 2, k);
    err_edge = 0;
    for (int i = 0; i < 60 && err_edge == 0; i++) begin
      if (o_err) err_edge = edge_cnt + 1;
      else step();
    end
    check("c err edge", err_edge, k + 18);
    check("c mv count", mv_q.size(), 1);
    if (mv_q.size() == 1) check("c mv0", mv_q[0], k + 1);
    check("c busy", o_busy, 0);
    i_sq = 5; i_iter = 1; i_start = 1'b1;
    step(); step();
    i_start = 1'b0;
    step(); step();
    check("c err held", o_err, 1);
    check("c start ignored", mv_q.size(), 1);
    check("c no done", done_q.size(), 0);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("c err cleared", o_err, 0);
    mute = 1'b0;
    step();

    // Overflow flagged on the second result of a five-step chain.
    clear_log();
    ovf_at = res_num + 2;
    start_chain(3, 5, k);
    wait_end(100, ok);
    check("d finished", ok, 1);
    step(); step();
    check("d err", o_err, 1);
    check("d iter_cnt", o_iter_cnt, 1);
    check("d result", o_result, 7);
    check("d no done", done_q.size(), 0);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    ovf_at = 0;
    check("d err cleared", o_err, 0);
    step();

    // Abort mid-chain, restart while a stale result is still in flight.
    clear_log();
    start_chain(3, 10, k);
    for (int i = 0; i < 20 && edge_cnt + 1 != k + 8; i++) step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    check("e busy after abort", o_busy, 0);
    check("e no done", done_q.size(), 0);
    clear_log();
    start_chain(2, 2, k2);
    wait_end(60, ok);
    check("e finished", ok, 1);
    step(); step();
    check("e result", o_result, 16);
    check("e iter_cnt", o_iter_cnt, 2);
    check("e done count", done_q.size(), 1);
    if (done_q.size() == 1) check("e done edge", done_q[0], k2 + 11);

    // Asynchronous reset in WAIT, then a fresh single squaring.
    clear_log();
    start_chain(3, 4, k);
    step(); step();
    check("f busy before rst", o_busy, 1);
    #2 i_rst = 1'b1;
    #1;
    check("f rst busy", o_busy, 0);
    check("f rst mul_sq", o_mul_sq, 0);
    check("f rst result", o_result, 0);
    check("f rst iter_cnt", o_iter_cnt, 0);
    check("f rst err", o_err, 0);
    check("f rst mul_val", o_mul_val, 0);
    step();
    i_rst = 1'b0;
    step();
    clear_log();
    start_chain(3, 1, k);
    wait_end(40, ok);
    check("f finished", ok, 1);
    step();
    check("f result", o_result, 9);
    check("f iter_cnt", o_iter_cnt, 1);
    if (done_q.size() == 1) check("f done edge", done_q[0], k + 6);
    else check("f done count", done_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
